data_mem_responder: RTL and testbench

- Memory-side responder for the CPU's data-memory request interface: services the MemEn / MemWrite / address / write-data requests the decode stage raises for lw/sw.
- Holds a word-organised RAM with per-byte write lanes and returns read data after a fixed, parameterised latency.
- Raises MemStall while a wait-stated access is in flight so the pipeline holds the memory-stage instruction.
- Sits between the EX/MEM pipeline register and the MEM/WB writeback mux.

---
 rtl/data_mem_responder_pkg.sv | 17 +
 rtl/data_mem_responder_ram.sv | 26 ++
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_responder_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // Byte lanes per 32-bit word.
    localparam int NUM_LANES = 4;

    // Zero wait states: every access responds on the next cycle.
    localparam int DEFAULT_WAIT_CYCLES = 0;

endpackage

// File: rtl/data_mem_responder_ram.sv
// DEPTH x 32 single-port array with per-byte write lanes and async read.
module data_ram_bank
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                 i_clk,
    input  logic [ADDR_W-1:0]    i_idx,
    input  logic [NUM_LANES-1:0] i_we,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Byte-lane write; lanes with a clear enable keep their old contents.
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (i_we[l]) r_mem[i_idx][8*l +: 8] <= i_wdata[8*l +: 8];
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts lw/sw requests, adds optional wait states,
// returns read data / address errors in a single RESP cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int WAIT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemEn,
    input  logic [NUM_LANES-1:0] MemWrite,
    input  logic [31:0]          MemAddr,
    input  logic [31:0]          MemWdata,
    output logic [31:0]          MemRdata,
    output logic                 RdataValid,
    output logic                 MemStall,
    output logic                 AddrErr
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                 r_state;
    state_t                 w_next;
    logic [WAIT_W-1:0]      r_cnt;
    logic [ADDR_W-1:0]      r_idx;
    logic [NUM_LANES-1:0]   r_we;
    logic [31:0]            r_wdata;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_req_err;
    logic                   w_is_read;
    logic [NUM_LANES-1:0]   w_ram_we;
    logic [31:0]            w_ram_rdata;
    logic                   w_unused_lsb;

    assign w_accept     = MemEn && (r_state == S_IDLE || r_state == S_RESP);
    assign w_req_err    = (MemAddr[31:2] >= 30'(DEPTH));
    assign w_is_read    = (r_we == '0);
    assign w_unused_lsb = ^MemAddr[1:0];

    // Commit happens on the edge leaving RESP; an error or a coincident
    // reset drops the write.
    assign w_ram_we = (r_state == S_RESP && !r_err && !rst) ? r_we : '0;

    // The single port is always addressed by the latched index. A read is
    // presented during its RESP cycle, so a write committed on the edge
    // entering that RESP is already in the array: this yields exactly the
    // old word merged with the committing lanes, i.e. the forwarded value,
    // while a write issued in the same RESP commits only afterwards.
    data_ram_bank #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (clk),
        .i_idx   (r_idx),
        .i_we    (w_ram_we),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // State register, wait counter and request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_we    <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx   <= MemAddr[ADDR_W+1:2];
                r_we    <= MemWrite;
                r_wdata <= MemWdata;
                r_err   <= w_req_err;
                r_cnt   <= WAIT_LOAD;
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Next-state and response outputs.
    always_comb begin
        w_next     = r_state;
        MemStall   = 1'b0;
        RdataValid = 1'b0;
        AddrErr    = 1'b0;
        MemRdata   = '0;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (r_state == S_RESP) begin
                    RdataValid = w_is_read;
                    AddrErr    = r_err;
                    MemRdata   = (w_is_read && !r_err) ? w_ram_rdata : '0;
                end
                if (MemEn) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                else       w_next = S_IDLE;
            end
            S_WAIT: begin
                MemStall = 1'b1;
                if (r_cnt == '0) w_next = S_RESP;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with no wait states, one with 3.
module tb_data_mem_responder;

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ev;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        en    [2];
    logic [3:0]  we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        valid [2];
    logic        stall [2];
    logic        aerr  [2];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst[0]), .MemEn(en[0]), .MemWrite(we[0]),
        .MemAddr(addr[0]), .MemWdata(wdata[0]), .MemRdata(rdata[0]),
        .RdataValid(valid[0]), .MemStall(stall[0]), .AddrErr(aerr[0])
    );

    data_mem_responder #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst[1]), .MemEn(en[1]), .MemWrite(we[1]),
        .MemAddr(addr[1]), .MemWdata(wdata[1]), .MemRdata(rdata[1]),
        .RdataValid(valid[1]), .MemStall(stall[1]), .AddrErr(aerr[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic check_out(input int d, input string tag, input logic ev,
                             input logic [31:0] erd, input logic eerr, input logic est);
        chk({tag, ".valid"}, 32'(valid[d]), 32'(ev));
        chk({tag, ".rdata"}, rdata[d], erd);
        chk({tag, ".err"},   32'(aerr[d]),  32'(eerr));
        chk({tag, ".stall"}, 32'(stall[d]), 32'(est));
    endtask

    task automatic drive(input int d, input logic e, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] wd);
        en[d] = e; we[d] = w; addr[d] = a; wdata[d] = wd;
    endtask

    function automatic vec_t mk(input logic e, input logic [3:0] w, input logic [31:0] a,
                                input logic [31:0] wd, input logic ev, input logic [31:0] erd,
                                input logic eerr);
        vec_t v;
        v.en = e; v.we = w; v.addr = a; v.wdata = wd;
        v.ev = ev; v.erd = erd; v.eerr = eerr;
        return v;
    endfunction

    initial begin
        vec_t        tbl [15];
        logic [31:0] mm [16];
        int          acc, rc, ninit, wc, idx;
        logic        oor, e, pv, perr;
        logic [3:0]  wl;
        logic [31:0] a, wd, prd;

        // Each row: request driven in that cycle, response expected in that cycle
        // (i.e. from the previous row's request).
        tbl[0]  = mk(1, 4'hF, 32'h0,    32'hCAFEF00D, 0, 32'h0, 0);
        tbl[1]  = mk(1, 4'hF, 32'h4,    32'h01020304, 0, 32'h0, 0);
        tbl[2]  = mk(1, 4'hF, 32'h8,    32'hA5A5A5A5, 0, 32'h0, 0);
        tbl[3]  = mk(1, 4'hF, 32'h40,   32'hDEADBEEF, 0, 32'h0, 0);
        tbl[4]  = mk(1, 4'h0, 32'h40,   32'h0,        0, 32'h0, 0);
        tbl[5]  = mk(1, 4'hF, 32'h80,   32'h11223344, 1, 32'hDEADBEEF, 0);
        tbl[6]  = mk(1, 4'h5, 32'h80,   32'hAABBCCDD, 0, 32'h0, 0);
        tbl[7]  = mk(1, 4'h0, 32'h82,   32'h0,        0, 32'h0, 0);
        tbl[8]  = mk(1, 4'hF, 32'h1000, 32'h12345678, 1, 32'h11BB33DD, 0);
        tbl[9]  = mk(1, 4'h0, 32'h1000, 32'h0,        0, 32'h0, 1);
        tbl[10] = mk(1, 4'h0, 32'h0,    32'h0,        1, 32'h0, 1);
        tbl[11] = mk(1, 4'h0, 32'h4,    32'h0,        1, 32'hCAFEF00D, 0);
        tbl[12] = mk(1, 4'h0, 32'h8,    32'h0,        1, 32'h01020304, 0);
        tbl[13] = mk(0, 4'h0, 32'h0,    32'h0,        1, 32'hA5A5A5A5, 0);
        tbl[14] = mk(0, 4'h0, 32'h0,    32'h0,        0, 32'h0, 0);

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            drive(d, 0, 4'h0, 32'h0, 32'h0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out(0, "reset0", 0, 32'h0, 0, 0);
        check_out(1, "reset3", 0, 32'h0, 0, 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Table vectors, zero wait states.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_out(0, $sformatf("vec%0d", i), tbl[i].ev, tbl[i].erd, tbl[i].eerr, 0);
            drive(0, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata);
        end

        // Three wait states: preload word 0x10.
        @(negedge clk); drive(1, 1, 4'hF, 32'h10, 32'h00000011);
        @(negedge clk); drive(1, 0, 4'h0, 32'h0, 32'h0);
        repeat (5) @(negedge clk);

        // Read with a stray request during the stall.
        drive(1, 1, 4'h0, 32'h10, 32'h0);                       // T
        @(negedge clk); check_out(1, "w3.t1", 0, 32'h0, 0, 1);
        drive(1, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk); check_out(1, "w3.t2", 0, 32'h0, 0, 1);
        drive(1, 1, 4'hF, 32'h10, 32'h00000BAD);
        @(negedge clk); check_out(1, "w3.t3", 0, 32'h0, 0, 1);
        drive(1, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk); check_out(1, "w3.t4", 1, 32'h00000011, 0, 0);
        for (int k = 5; k < 8; k++) begin
            @(negedge clk); check_out(1, $sformatf("w3.t%0d", k), 0, 32'h0, 0, 0);
        end

        // Reset in the middle of a wait-stated store.
        drive(1, 1, 4'hF, 32'h10, 32'h00000055);                // T
        @(negedge clk); check_out(1, "rst.t1", 0, 32'h0, 0, 1);
        drive(1, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk); rst[1] = 1'b1;
        @(negedge clk); check_out(1, "rst.t3", 0, 32'h0, 0, 0);
        rst[1] = 1'b0;
        @(negedge clk); drive(1, 1, 4'h0, 32'h10, 32'h0);       // T+4
        for (int k = 5; k < 8; k++) begin
            @(negedge clk); check_out(1, $sformatf("rst.t%0d", k), 0, 32'h0, 0, 1);
            drive(1, 0, 4'h0, 32'h0, 32'h0);
        end
        @(negedge clk); check_out(1, "rst.t8", 1, 32'h00000011, 0, 0);

        // Random traffic against a transaction-level model: requests take effect
        // in program order; a request accepted at cycle c answers at c+W+1 and
        // the cycles in between stall and ignore the bus.
        for (int d = 0; d < 2; d++) begin
            wc = (d == 0) ? 0 : 3;
            acc = -100; rc = -100; ninit = 0;
            pv = 0; prd = 0; perr = 0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (c == rc) check_out(d, $sformatf("rnd%0d.c%0d", d, c), pv, prd, perr, 0);
                else check_out(d, $sformatf("rnd%0d.c%0d", d, c), 0, 32'h0, 0,
                               (c > acc && c < rc));
                if (ninit < 16) begin
                    e = 1; wl = 4'hF; idx = ninit; oor = 0; wd = $urandom;
                end else begin
                    e   = ($urandom_range(0, 3) != 0);
                    wl  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                    idx = $urandom_range(0, 15);
                    oor = ($urandom_range(0, 7) == 0);
                    wd  = $urandom;
                end
                a = (oor ? 32'h1000 : 32'h0) + 32'(idx * 4) + 32'($urandom_range(0, 3));
                drive(d, e, wl, a, wd);
                if (e && c >= rc) begin
                    if (ninit < 16) ninit++;
                    pv   = (wl == 4'h0);
                    perr = oor;
                    prd  = (pv && !oor) ? mm[idx] : 32'h0;
                    if (!oor)
                        for (int l = 0; l < 4; l++)
                            if (wl[l]) mm[idx][8*l +: 8] = wd[8*l +: 8];
                    acc = c;
                    rc  = c + wc + 1;
                end
            end
            @(negedge clk);
            drive(d, 0, 4'h0, 32'h0, 32'h0);
            repeat (6) @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
